// File: rtl/fft_frame_streamer.sv
// Captures one contiguous FFT frame into block RAM and, on a host request edge, streams
// it over 8N1 UART as a header byte then payload MSB-first. FFT_STREAM_CHECKSUM_EN appends an XOR byte.
`timescale 1ns/1ps
module fft_frame_streamer #(
   parameter int         CLK_HZ    = 100000000,
   parameter int         BAUD      = 115200,
   parameter int         DATA_W    = 32,
   parameter int         FRAME_LEN = 1024,
   parameter int         IDX_W     = 16,
   parameter logic [7:0] HEADER    = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic [IDX_W-1:0]  s_index,
   input  logic              rx_ready,
   output logic              tx_ready,
   output logic              tx,
   output logic              busy,
   output logic              ovf
);
   localparam int BAUD_DIV = CLK_HZ / BAUD;
   localparam int BYTES    = DATA_W / 8;
   localparam int AW       = $clog2(FRAME_LEN);
   localparam int BC_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int BD_W     = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      ARM, CAPTURE, WAIT_HOST, SEND_HDR, SEND_DATA, SEND_END
   } state_t;

   state_t            state_reg, state_next;
   logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [BC_W-1:0]   byte_cnt_reg, byte_cnt_next;
   logic [BD_W-1:0]   baud_cnt_reg, baud_cnt_next;
   logic [3:0]        bit_cnt_reg, bit_cnt_next;
   logic [7:0]        shift_reg, shift_next;
   logic              tx_reg, tx_next;
   logic              ovf_reg, ovf_next;
   logic              final_reg, final_next;
   logic [2:0]        rx_sync_reg;
`ifdef FFT_STREAM_CHECKSUM_EN
   logic [7:0]        chk_reg, chk_next;
   logic              done_reg, done_next;
`endif

   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] rd_data_reg;
   logic [7:0]        lane [BYTES];
   logic [7:0]        cur_byte;
   logic              rx_rise;
   logic              last_payload;

   // Frame buffer: one write port from the capture side, one registered read port for the sender.
   logic [DATA_W-1:0] mem [FRAME_LEN];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= s_data;
      rd_data_reg <= mem[rd_ptr_reg];
   end

   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
         assign lane[gi] = rd_data_reg[gi*8 +: 8];
      end
   endgenerate

   assign cur_byte     = lane[BC_W'(BYTES-1) - byte_cnt_reg];
   assign last_payload = (rd_ptr_reg == AW'(FRAME_LEN-1)) && (byte_cnt_reg == BC_W'(BYTES-1));
   assign rx_rise      = rx_sync_reg[1] & ~rx_sync_reg[2];

   always_comb begin
      state_next    = state_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      byte_cnt_next = byte_cnt_reg;
      baud_cnt_next = baud_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      tx_next       = tx_reg;
      ovf_next      = ovf_reg;
      final_next    = final_reg;
      wr_en         = 1'b0;
      wr_addr       = wr_ptr_reg;
`ifdef FFT_STREAM_CHECKSUM_EN
      chk_next      = chk_reg;
      done_next     = done_reg;
`endif

      case (state_reg)
         ARM: begin
            if (s_valid && s_index == '0) begin
               wr_en       = 1'b1;
               wr_addr     = '0;
               wr_ptr_next = AW'(1);
               state_next  = CAPTURE;
            end
         end

         CAPTURE: begin
            if (s_valid) begin
               if (s_index == IDX_W'(wr_ptr_reg)) begin
                  wr_en       = 1'b1;
                  wr_ptr_next = wr_ptr_reg + AW'(1);
                  if (wr_ptr_reg == AW'(FRAME_LEN-1))
                     state_next = WAIT_HOST;
               end else if (s_index == '0) begin
                  // Out-of-order index 0 restarts the frame in place.
                  wr_en       = 1'b1;
                  wr_addr     = '0;
                  wr_ptr_next = AW'(1);
               end else begin
                  wr_ptr_next = '0;
                  state_next  = ARM;
               end
            end
         end

         WAIT_HOST: begin
            if (rx_rise) begin
               state_next    = SEND_HDR;
               tx_next       = 1'b0;
               shift_next    = HEADER;
               bit_cnt_next  = '0;
               baud_cnt_next = '0;
               rd_ptr_next   = '0;
               byte_cnt_next = '0;
               final_next    = 1'b0;
`ifdef FFT_STREAM_CHECKSUM_EN
               chk_next      = '0;
               done_next     = 1'b0;
`endif
            end
         end

         SEND_HDR, SEND_DATA, SEND_END: begin
            if (baud_cnt_reg != BD_W'(BAUD_DIV-1)) begin
               baud_cnt_next = baud_cnt_reg + BD_W'(1);
            end else begin
               baud_cnt_next = '0;
               if (bit_cnt_reg == 4'd9) begin
                  // End of a stop bit: finish the frame or start the next byte with no gap.
                  if (state_reg == SEND_END) begin
                     state_next = ARM;
`ifdef FFT_STREAM_CHECKSUM_EN
                  end else if (done_reg) begin
                     tx_next      = 1'b0;
                     shift_next   = chk_reg;
                     bit_cnt_next = '0;
                     final_next   = 1'b1;
`endif
                  end else begin
                     tx_next      = 1'b0;
                     shift_next   = cur_byte;
                     bit_cnt_next = '0;
                     state_next   = SEND_DATA;
`ifdef FFT_STREAM_CHECKSUM_EN
                     chk_next     = chk_reg ^ cur_byte;
                     done_next    = last_payload;
`else
                     final_next   = last_payload;
`endif
                     // Advancing now lets the registered read settle well before the next load.
                     if (byte_cnt_reg == BC_W'(BYTES-1)) begin
                        byte_cnt_next = '0;
                        rd_ptr_next   = rd_ptr_reg + AW'(1);
                     end else begin
                        byte_cnt_next = byte_cnt_reg + BC_W'(1);
                     end
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd8) begin
                     tx_next = 1'b1;
                     if (final_reg)
                        state_next = SEND_END;
                  end else begin
                     tx_next    = shift_reg[0];
                     shift_next = {1'b0, shift_reg[7:1]};
                  end
               end
            end
         end

         default: state_next = ARM;
      endcase

      if (state_reg inside {WAIT_HOST, SEND_HDR, SEND_DATA, SEND_END} && s_valid && s_index == '0)
         ovf_next = 1'b1;
      if (state_next == ARM && state_reg != ARM)
         ovf_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ARM;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         byte_cnt_reg <= '0;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         ovf_reg      <= 1'b0;
         final_reg    <= 1'b0;
         rx_sync_reg  <= '0;
`ifdef FFT_STREAM_CHECKSUM_EN
         chk_reg      <= '0;
         done_reg     <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         byte_cnt_reg <= byte_cnt_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
         ovf_reg      <= ovf_next;
         final_reg    <= final_next;
         rx_sync_reg  <= {rx_sync_reg[1:0], rx_ready};
`ifdef FFT_STREAM_CHECKSUM_EN
         chk_reg      <= chk_next;
         done_reg     <= done_next;
`endif
      end
   end

   assign tx       = tx_reg;
   assign tx_ready = (state_reg != WAIT_HOST);
   assign busy     = (state_reg == SEND_HDR) || (state_reg == SEND_DATA) || (state_reg == SEND_END);
   assign ovf      = ovf_reg;

endmodule
